// File: rtl/risc_control_fsm_if.sv
// risc_control_fsm_if: control-unit bus; master = control unit (drives *_o), slave = datapath/memory side (drives instr_i, mem_ready_i, zero_i)
interface risc_control_fsm_if;
  logic [15:0] instr_i;
  logic        mem_ready_i;
  logic        zero_i;
  logic [15:0] ir_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic        addr_sel_o;
  logic        ir_load_o;
  logic        pc_write_o;
  logic [1:0]  pc_src_o;
  logic [3:0]  alu_control_o;
  logic        alu_src_b_o;
  logic        reg_write_o;
  logic        wb_sel_o;
  logic        halted_o;
  logic [2:0]  state_o;
  modport master (
    input  instr_i, mem_ready_i, zero_i,
    output ir_o, mem_req_o, mem_we_o, addr_sel_o, ir_load_o, pc_write_o, pc_src_o,
           alu_control_o, alu_src_b_o, reg_write_o, wb_sel_o, halted_o, state_o
  );
  modport slave (
    output instr_i, mem_ready_i, zero_i,
    input  ir_o, mem_req_o, mem_we_o, addr_sel_o, ir_load_o, pc_write_o, pc_src_o,
           alu_control_o, alu_src_b_o, reg_write_o, wb_sel_o, halted_o, state_o
  );
endinterface

// File: rtl/risc_control_fsm.sv
// risc_control_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit; ports clk_i, reset_i (async high) and bus (master: memory handshake, IR, PC/ALU/regfile strobes, halted, state)
module risc_control_fsm (
  input  logic                       clk_i,
  input  logic                       reset_i,
  risc_control_fsm_if.master         bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;
  state_t      state_q, state_d;
  logic [15:0] ir_q;
  logic [3:0]  op;
  logic        is_alu, is_imm, is_ld, is_st, rdy;
  logic        mem_req, mem_we, addr_sel, ir_load, pc_write, alu_src_b, reg_write, wb_sel, halted;
  logic [1:0]  pc_src;
  logic [3:0]  alu_control;
  assign op     = ir_q[15:12];
  assign is_alu = op <= 4'h8;
  assign is_ld  = op == 4'hA;
  assign is_st  = op == 4'hB;
  assign is_imm = op == 4'h9 || is_ld || is_st;
  assign rdy    = bus.mem_ready_i;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir_q <= bus.instr_i;
    end
  end
  always_comb begin
    state_d     = FETCH;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    alu_control = 4'h0;
    alu_src_b   = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 1'b0;
    halted      = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req  = 1'b1;
        ir_load  = rdy;
        pc_write = rdy;
        state_d  = rdy ? DECODE : FETCH;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        alu_control = is_alu ? op : (op == 4'hC ? 4'h1 : 4'h0);
        alu_src_b   = is_imm;
        pc_write    = op == 4'hD || (op == 4'hC && bus.zero_i);
        pc_src      = op == 4'hD ? 2'b10 : (op == 4'hC && bus.zero_i ? 2'b01 : 2'b00);
        state_d     = (is_alu || op == 4'h9) ? WB : (is_ld || is_st) ? MEM : op == 4'hF ? HALT : FETCH;
      end
      MEM: begin
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        alu_src_b = 1'b1;
        mem_we    = is_st;
        state_d   = !rdy ? MEM : is_st ? FETCH : WB;
      end
      WB: begin
        reg_write   = 1'b1;
        wb_sel      = is_ld;
        alu_control = is_alu ? op : 4'h0;
        alu_src_b   = is_imm;
      end
      HALT: begin
        halted  = 1'b1;
        state_d = HALT;
      end
      default: state_d = FETCH;
    endcase
  end
  assign bus.ir_o          = ir_q;
  assign bus.mem_req_o     = mem_req & ~reset_i;
  assign bus.mem_we_o      = mem_we & ~reset_i;
  assign bus.addr_sel_o    = addr_sel & ~reset_i;
  assign bus.ir_load_o     = ir_load & ~reset_i;
  assign bus.pc_write_o    = pc_write & ~reset_i;
  assign bus.pc_src_o      = reset_i ? 2'b00 : pc_src;
  assign bus.alu_control_o = reset_i ? 4'h0 : alu_control;
  assign bus.alu_src_b_o   = alu_src_b & ~reset_i;
  assign bus.reg_write_o   = reg_write & ~reset_i;
  assign bus.wb_sel_o      = wb_sel & ~reset_i;
  assign bus.halted_o      = halted & ~reset_i;
  assign bus.state_o       = reset_i ? 3'd0 : state_q;
endmodule

// File: doc/risc_control_fsm.md
# risc_control_fsm

Multi-cycle control unit for the 16-bit RISC core. It fetches and decodes instructions and sequences the datapath through the FETCH, DECODE, EXEC, MEM and WB states. It drives the 4-bit ALU operation code and operand select into the ALU and consumes the ALU zero flag for branches. It also handshakes with the unified instruction/data memory port.

## Interface
Parameters: none (16-bit instruction, 4-bit opcode, 4-bit ALU code fixed).
- clk  in  1  single clock, all state rising-edge
- reset  in  1  asynchronous, active-high
- instr_in  in  16  memory read data, captured into IR at fetch completion
- mem_ready  in  1  memory handshake complete this cycle
- zero  in  1  ALU zero flag (combinational from ALU)
- ir  out  16  instruction register: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, valid with mem_req
- addr_sel  out  1  0 = PC, 1 = ALU result
- ir_load  out  1  IR capture strobe
- pc_write  out  1  PC update strobe
- pc_src  out  2  00 = PC+1, 01 = PC+sext(imm4), 10 = {PC[15:12], ir[11:0]}
- alu_control  out  4  ALU op code
- alu_src_b  out  1  0 = register rs2/rd, 1 = sext(imm4)
- reg_write  out  1  register file write strobe
- wb_sel  out  1  0 = ALU result, 1 = memory data
- halted  out  1  core halted
- state  out  3  current state (debug)

## Operation
- Opcodes:
  - 0x0–0x8 are ALU ops; alu_control = opcode: ADD, SUB, NOT, SHL, SHR, AND, OR, INC, DEC.
  - 0x9 ADDI, 0xA LD, 0xB ST, 0xC BEQ, 0xD JMP, 0xE NOP, 0xF HALT.
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 → FETCH.
- FETCH:
  - Drives mem_req=1, addr_sel=0.
  - Holds until mem_ready. In the ready cycle: ir_load=1, pc_write=1, pc_src=00. Next state DECODE.
- DECODE: one cycle (register read). All strobes 0.
- EXEC:
  - ALU ops 0x0–0x8: alu_control=opcode, alu_src_b=0 → WB.
  - ADDI, LD, ST: alu_control=0000, alu_src_b=1. ADDI → WB; LD, ST → MEM.
  - BEQ: alu_control=0001, alu_src_b=0 (rs1 − rd). If zero=1, pc_write=1, pc_src=01. → FETCH.
  - JMP: pc_write=1, pc_src=10 → FETCH.
  - NOP → FETCH.
  - HALT → HALT.
- MEM:
  - Drives mem_req=1, addr_sel=1, alu_control=0000, alu_src_b=1 (address held stable). mem_we=1 for ST.
  - Holds until mem_ready. ST → FETCH; LD → WB.
- WB:
  - reg_write=1. wb_sel=1 for LD, else 0. ALU controls repeat the EXEC values so the result stays stable. → FETCH.
- HALT: halted=1, all strobes 0. Sticky until reset.
- Outputs are decoded from the registered state and IR. Any strobe not listed for a state is 0. alu_control defaults to 0000 and alu_src_b to 0.
- mem_ready outside FETCH/MEM is ignored.

## Timing
- Reset (async, active-high):
  - Sets state=FETCH and ir=0x0000.
  - While reset is high, every output is forced to 0 (state output reads 0).
  - The first FETCH request appears in the first cycle after deassertion.
- Cycle counts with zero-wait memory:
  - ALU op / ADDI: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - BEQ, JMP, NOP, HALT entry: 3 cycles.
- Each memory wait cycle adds 1 cycle. During a wait, mem_req, mem_we and addr_sel stay constant.
- zero is sampled only in EXEC for BEQ, in the same cycle as alu_control=0001.
- IR changes only on an ir_load cycle. PC strobes never occur in DECODE, MEM or WB.
- Reset asserted mid-instruction (e.g. during a MEM wait) aborts immediately. No reg_write or mem_we pulse follows.

## Test plan
- Reset then ADD (instr 0x0123), mem_ready always 1:
  - state sequence 0,1,2,4,0.
  - alu_control=0000 in EXEC; reg_write=1, wb_sel=0 in WB only.
  - pc_write=1 once, in FETCH.
- LD (0xA215) with 2-cycle memory wait in MEM:
  - mem_req=1, addr_sel=1 held 3 cycles; mem_we=0.
  - Then WB with wb_sel=1, reg_write=1. Total 7 cycles.
- BEQ (0xC013):
  - zero=1 in EXEC → pc_write=1, pc_src=01.
  - Repeat with zero=0 → pc_write=0. Both return to FETCH after 3 cycles.
- ST (0xB215), then JMP (0xD0FF):
  - ST: mem_we=1 only in MEM, no reg_write.
  - JMP: pc_src=10, pc_write=1 in EXEC.
- HALT (0xF000):
  - halted=1 from cycle 4 onward; no mem_req for 20 cycles.
  - Async reset returns to FETCH with halted=0.
- Reset pulse mid-MEM wait of an ST:
  - All outputs 0 immediately; ir=0x0000.
  - No mem_we pulse; FETCH restarts after deassertion.
